// File: rtl/booth_multiplier_seq.sv
// Sequential signed Booth multiplier: one recoding step per clock, registered product with a done strobe.
// Define BOOTH_RADIX4_EN for modified (radix-4) recoding, which halves the number of steps.
module booth_multiplier_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef BOOTH_RADIX4_EN
  localparam int unsigned AW    = WIDTH + 2;
  localparam int unsigned STEPS = WIDTH / 2;
`else
  localparam int unsigned AW    = WIDTH + 1;
  localparam int unsigned STEPS = WIDTH;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   m, m_d;
  logic [WIDTH-1:0]   q, q_d;
  logic [AW-1:0]      acc, acc_d;
  logic               q_m1, q_m1_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic               busy_d, done_d;
  logic [2*WIDTH-1:0] product_d;

  logic [AW-1:0]      m_ext;
  logic [AW-1:0]      sum;
  logic [AW-1:0]      acc_sh;
  logic [WIDTH-1:0]   q_sh;
  logic               q_m1_sh;

  assign m_ext = {{(AW-WIDTH){m[WIDTH-1]}}, m};

`ifdef BOOTH_RADIX4_EN
  logic [AW-1:0] m2_ext;
  assign m2_ext = {m_ext[AW-2:0], 1'b0};

  // Radix-4 recode of {Q[1],Q[0],q_m1}, then arithmetic shift of {acc,Q,q_m1} by two
  always_comb begin
    sum = acc;
    case ({q[1:0], q_m1})
      3'b001, 3'b010: sum = acc + m_ext;
      3'b011:         sum = acc + m2_ext;
      3'b100:         sum = acc - m2_ext;
      3'b101, 3'b110: sum = acc - m_ext;
      default:        sum = acc;
    endcase
    {acc_sh, q_sh, q_m1_sh} = {{2{sum[AW-1]}}, sum, q[WIDTH-1:1]};
  end
`else
  // Radix-2 recode of {Q[0],q_m1}, then arithmetic shift of {acc,Q,q_m1} by one
  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
    {acc_sh, q_sh, q_m1_sh} = {sum[AW-1], sum, q};
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state   <= state_d;
      m       <= m_d;
      q       <= q_d;
      acc     <= acc_d;
      q_m1    <= q_m1_d;
      cnt     <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      product <= product_d;
    end
  end

  // Next-state and next-output logic; start is ignored while RUN
  always_comb begin
    state_d   = state;
    m_d       = m;
    q_d       = q;
    acc_d     = acc;
    q_m1_d    = q_m1;
    cnt_d     = cnt;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    product_d = product;
    case (state)
      IDLE: begin
        if (start) begin
          m_d     = A;
          q_d     = B;
          acc_d   = '0;
          q_m1_d  = 1'b0;
          cnt_d   = CW'(STEPS);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_sh;
        q_d    = q_sh;
        q_m1_d = q_m1_sh;
        cnt_d  = cnt - CW'(1);
        busy_d = 1'b1;
        if (cnt == CW'(1)) begin
          product_d = {acc_sh[WIDTH-1:0], q_sh};
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
Sequential radix-2 Booth multiplier, directly downstream of the keypad operand storage stage.
- Accepts two signed two's-complement operands A (multiplicand) and B (multiplier) plus a start pulse.
- Iterates one Booth step per clock.
- Presents a 2*WIDTH-bit signed product with a one-cycle done strobe, for the display/BCD conversion stage.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset, asynchronous, active-low
start  input  1  request pulse; sampled only in IDLE
A  input  WIDTH  signed multiplicand
B  input  WIDTH  signed multiplier
busy  output  1  high while a multiplication is in progress
done  output  1  one-cycle strobe; product updated in same cycle
product  output  2*WIDTH  signed product A*B; held until next done

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, product=0, done=0, busy=0, all internal registers 0.
- Reset mid-operation aborts the multiplication with no done strobe; product returns to 0.
- Internal registers:
  - M: WIDTH-bit copy of A.
  - acc: WIDTH+1 bits, sign-extended, so that acc-M with M = -2^(WIDTH-1) cannot overflow.
  - Q: WIDTH bits.
  - q_m1: 1 bit.
  - cnt: clog2(WIDTH+1) bits.
- States:
  - IDLE: done=0 except in the strobe cycle, busy=0. On an edge with start=1: M<=A, Q<=B, acc<=0, q_m1<=0, cnt<=WIDTH, state->RUN.
  - RUN: busy=1. Each edge performs one Booth step:
    - Compute {Q[0],q_m1}: 01 -> acc+sext(M); 10 -> acc-sext(M); 00/11 -> acc unchanged.
    - Arithmetic right shift of {acc_new,Q,q_m1} by 1 (MSB of acc replicated).
    - cnt <= cnt-1.
  - Last step (cnt==1): same edge loads product <= {acc,Q} after shift, low 2*WIDTH bits. Also done<=1, busy<=0, state->IDLE.
- Timing:
  - Latency: start sampled at edge E0; done and product valid in the cycle after edge E0+WIDTH (8 clocks for WIDTH=8).
  - busy is high during cycles E0+1 .. E0+WIDTH, inclusive of the cycle before done.
- Operand capture: A and B are captured only at E0. Later changes on A/B have no effect on the running operation.
- start while busy=1: ignored. It is not queued and has no effect on the running result.
- start high in the done-strobe cycle: accepted (state is IDLE). The next operation begins and done falls next cycle.
- start held high continuously: a new operation starts on every IDLE edge. This gives back-to-back results every WIDTH+1 cycles.
- Product must equal the exact signed product for all 2^(2*WIDTH) operand pairs, including (-2^(WIDTH-1))^2.

Optional Feature:
BOOTH_RADIX4_EN
- Defined:
  - Modified (radix-4) Booth recoding of {Q[1],Q[0],q_m1}: 000/111 -> +0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - acc is WIDTH+2 bits.
  - Arithmetic right shift by 2 per step; cnt loads WIDTH/2.
  - Latency: done in the cycle after edge E0+WIDTH/2 (4 clocks for WIDTH=8).
  - All handshake, reset and start-ignore rules are unchanged.
- Undefined: radix-2 behaviour as above.

Test Plan:
- Basic: A=7, B=3, start 1 cycle. Expect busy high 8 cycles, then done 1 cycle with product=0x0015; product holds 0x0015 afterwards.
- Signed corners:
  - A=-128, B=-128 -> 0x4000.
  - A=127, B=-128 -> 0xC080.
  - A=-5, B=12 -> 0xFFC4.
  - A=0, B=-1 -> 0x0000.
  - Each must produce exactly one done strobe.
- Operand/start stability: start with A=10, B=10, then change A=99 and B=99 and pulse start at cycle 3 while busy. Expect a single done with product=0x0064, and no second done.
- Reset mid-op: start A=25, B=4, drop rst at cycle 4 for 2 cycles. Expect product=0, busy=0, no done. A fresh start afterwards yields 0x0064.
- Back-to-back: start held high with A=2, B=3, then A=-3, B=3 from the done cycle. Expect done strobes 9 cycles apart with products 0x0006 then 0xFFF7.
- BOOTH_RADIX4_EN build: repeat scenarios 1-2. Expect identical products with done 4 cycles after start; random sweep of 10k signed pairs against a reference model.
